ecg_pattern_generator: RTL and testbench



---
 rtl/ecg_pattern_generator_if.sv | 27 ++
 rtl/ecg_pattern_generator.sv | 164 ++++++++++++++++
 tb/tb_ecg_pattern_generator.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecg_pattern_generator_if.sv
// rtl/ecg_pattern_generator_if.sv - sample stream bundle between the ECG generator and its consumer
// Ports:
//   enable, sample_tick, rr_period, noise_en    : control, driven by the consumer
//   ecg_signal, sample_valid, beat_marker,
//   beat_count                                  : sample stream, driven by the generator
// master = generator side, slave = consumer / bench side.
`timescale 1ns/1ps
interface ecg_pattern_generator_if;
  logic        enable;
  logic        sample_tick;
  logic [15:0] rr_period;
  logic        noise_en;
  logic [15:0] ecg_signal;
  logic        sample_valid;
  logic        beat_marker;
  logic [15:0] beat_count;

  modport master (
    input  enable, sample_tick, rr_period, noise_en,
    output ecg_signal, sample_valid, beat_marker, beat_count
  );

  modport slave (
    output enable, sample_tick, rr_period, noise_en,
    input  ecg_signal, sample_valid, beat_marker, beat_count
  );
endinterface

// File: rtl/ecg_pattern_generator.sv
// rtl/ecg_pattern_generator.sv - synthetic ECG beat source with R-peak markers and optional LFSR noise
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   bus (master) : enable, sample_tick, rr_period, noise_en in;
//                  ecg_signal, sample_valid, beat_marker, beat_count out
`timescale 1ns/1ps
module ecg_pattern_generator #(
  parameter int BASELINE   = 1000,
  parameter int P_AMP      = 400,
  parameter int QRS_AMP    = 8000,
  parameter int T_AMP      = 800,
  parameter int P_LEN      = 8,
  parameter int PR_LEN     = 4,
  parameter int QRS_HALF   = 4,
  parameter int ST_LEN     = 8,
  parameter int T_LEN      = 16,
  parameter int NOISE_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ecg_pattern_generator_if.master bus
);

  localparam int          FIXED_LEN   = P_LEN + PR_LEN + 2 * QRS_HALF + ST_LEN + T_LEN;
  localparam logic [15:0] FIXED_LEN16 = 16'(FIXED_LEN);
  localparam int          P_STEP      = P_AMP / (P_LEN / 2);
  localparam int          Q_STEP      = QRS_AMP / QRS_HALF;
  localparam int          T_STEP      = T_AMP / (T_LEN / 2);

  typedef enum logic [2:0] {
    IDLE, P_WAVE, PR_SEG, QRS_UP, QRS_DOWN, ST_SEG, T_WAVE, BASE_SEG
  } state_t;

  state_t      state_q, state_d, seg_state, seg_next;
  logic [15:0] k_q, k_d;
  logic [15:0] rr_eff_q, rr_eff_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] ecg_q, ecg_d;
  logic [15:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        marker_q, marker_d;

  logic [15:0] rr_clamped, rr_cur, base_len, wave;
  logic [16:0] noisy;
  logic        seg_last;
  int          kk, wi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      rr_eff_q <= '0;
      lfsr_q   <= 16'hACE1;
      ecg_q    <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      marker_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      rr_eff_q <= rr_eff_d;
      lfsr_q   <= lfsr_d;
      ecg_q    <= ecg_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      marker_q <= marker_d;
    end
  end

  always_comb begin
    rr_clamped = (bus.rr_period < FIXED_LEN16) ? FIXED_LEN16 : bus.rr_period;

    // IDLE is treated as the first sample of a fresh P wave whose period is
    // latched on the same tick.
    seg_state = (state_q == IDLE) ? P_WAVE : state_q;
    kk        = (state_q == IDLE) ? 0 : int'(k_q);
    rr_cur    = (state_q == IDLE) ? rr_clamped : rr_eff_q;
    base_len  = rr_cur - FIXED_LEN16;

    wi       = BASELINE;
    seg_last = 1'b0;
    seg_next = seg_state;
    case (seg_state)
      P_WAVE: begin
        wi       = (kk < P_LEN / 2) ? BASELINE + (kk + 1) * P_STEP
                                    : BASELINE + (P_LEN - 1 - kk) * P_STEP;
        seg_last = (kk == P_LEN - 1);
        seg_next = PR_SEG;
      end
      PR_SEG: begin
        seg_last = (kk == PR_LEN - 1);
        seg_next = QRS_UP;
      end
      QRS_UP: begin
        wi       = BASELINE + (kk + 1) * Q_STEP;
        seg_last = (kk == QRS_HALF - 1);
        seg_next = QRS_DOWN;
      end
      QRS_DOWN: begin
        wi       = BASELINE + QRS_AMP - (kk + 1) * Q_STEP;
        seg_last = (kk == QRS_HALF - 1);
        seg_next = ST_SEG;
      end
      ST_SEG: begin
        seg_last = (kk == ST_LEN - 1);
        seg_next = T_WAVE;
      end
      T_WAVE: begin
        wi       = (kk < T_LEN / 2) ? BASELINE + (kk + 1) * T_STEP
                                    : BASELINE + (T_LEN - 1 - kk) * T_STEP;
        seg_last = (kk == T_LEN - 1);
        // A period equal to the fixed part leaves no baseline gap.
        seg_next = (base_len == '0) ? P_WAVE : BASE_SEG;
      end
      BASE_SEG: begin
        seg_last = (kk == int'(base_len) - 1);
        seg_next = P_WAVE;
      end
      default: ;
    endcase

    wave  = 16'(wi);
    noisy = {1'b0, wave} + 17'(lfsr_q[NOISE_BITS-1:0]);

    state_d  = state_q;
    k_d      = k_q;
    rr_eff_d = rr_eff_q;
    lfsr_d   = lfsr_q;
    ecg_d    = ecg_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    marker_d = 1'b0;

    if (!bus.enable) begin
      // ecg_signal, lfsr and beat_count deliberately hold across a disable.
      state_d = IDLE;
      k_d     = '0;
    end else if (bus.sample_tick) begin
      valid_d  = 1'b1;
      marker_d = (seg_state == QRS_UP) && seg_last;
      if (marker_d) count_d = count_q + 16'd1;
      if (!bus.noise_en)  ecg_d = wave;
      else if (noisy[16]) ecg_d = 16'hFFFF;
      else                ecg_d = noisy[15:0];
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (state_q == IDLE) rr_eff_d = rr_clamped;
      if (seg_last) begin
        state_d = seg_next;
        k_d     = '0;
        if (seg_next == P_WAVE) rr_eff_d = rr_clamped;
      end else begin
        state_d = seg_state;
        k_d     = k_q + 16'd1;
      end
    end
  end

  assign bus.ecg_signal   = ecg_q;
  assign bus.sample_valid = valid_q;
  assign bus.beat_marker  = marker_q;
  assign bus.beat_count   = count_q;

endmodule

// File: tb/tb_ecg_pattern_generator.sv
// tb/tb_ecg_pattern_generator.sv - scoreboard bench for ecg_pattern_generator
`timescale 1ns/1ps
module tb_ecg_pattern_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst2_n;

  ecg_pattern_generator_if bus1 ();
  ecg_pattern_generator_if bus2 ();

  ecg_pattern_generator u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.master)
  );

  ecg_pattern_generator #(.BASELINE(57535)) u_sat (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2.master)
  );

  typedef struct {
    int val;
    bit mk;
    int bc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  int pos, rr_cur, mbc;
  logic [15:0] mlfsr;
  int pos2, mbc2;
  logic [15:0] mlfsr2;
  bit done2 = 1'b0;

  int sidx = 0;
  int log_v [512];
  bit log_m [512];
  int log_bc [512];
  int sidx2 = 0;
  int log2_v [64];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Beat shape for the default parameter set, indexed by sample within the beat.
  function automatic int shape(input int i, input int b);
    int j;
    if (i < 8)  return (i < 4) ? b + (i + 1) * 100 : b + (7 - i) * 100;
    if (i < 12) return b;
    if (i < 16) return b + (i - 11) * 2000;
    if (i < 20) return b + 8000 - (i - 15) * 2000;
    if (i < 28) return b;
    if (i < 44) begin
      j = i - 28;
      return (j < 8) ? b + (j + 1) * 100 : b + (15 - j) * 100;
    end
    return b;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int emit(input int w, input logic [15:0] l, input bit en);
    int s;
    s = en ? w + int'(l[3:0]) : w;
    return (s > 65535) ? 65535 : s;
  endfunction

  task automatic push1();
    exp_t e;
    if (pos == 0) rr_cur = (int'(bus1.rr_period) < 44) ? 44 : int'(bus1.rr_period);
    e.val = emit(shape(pos, 1000), mlfsr, bus1.noise_en);
    e.mk  = (pos == 15);
    if (e.mk) mbc = (mbc + 1) % 65536;
    e.bc  = mbc;
    q1.push_back(e);
    mlfsr = lfsr_next(mlfsr);
    pos++;
    if (pos == rr_cur) pos = 0;
  endtask

  task automatic run1(input int n);
    for (int i = 0; i < n; i++) begin
      push1();
      bus1.sample_tick = 1'b1;
      @(posedge clk);
      #1;
    end
    bus1.sample_tick = 1'b0;
  endtask

  task automatic drain1();
    for (int i = 0; i < 10 && q1.size() != 0; i++) @(posedge clk);
    #1;
    check("drain1_queue", q1.size(), 0);
  endtask

  task automatic reset1();
    bus1.sample_tick = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_ecg_signal", bus1.ecg_signal, 0);
    check("rst_sample_valid", bus1.sample_valid, 0);
    check("rst_beat_marker", bus1.beat_marker, 0);
    check("rst_beat_count", bus1.beat_count, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pos   = 0;
    mbc   = 0;
    mlfsr = 16'hACE1;
    sidx  = 0;
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && bus1.sample_valid) begin
      if (q1.size() == 0) begin
        check("sample_valid_unexpected", bus1.sample_valid, 0);
      end else begin
        e = q1.pop_front();
        check("ecg_signal", bus1.ecg_signal, e.val);
        check("beat_marker", bus1.beat_marker, e.mk);
        check("beat_count", bus1.beat_count, e.bc);
      end
      if (sidx < 512) begin
        log_v[sidx]  = bus1.ecg_signal;
        log_m[sidx]  = bus1.beat_marker;
        log_bc[sidx] = bus1.beat_count;
      end
      sidx++;
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst2_n && bus2.sample_valid) begin
      if (q2.size() == 0) begin
        check("sat_valid_unexpected", bus2.sample_valid, 0);
      end else begin
        e = q2.pop_front();
        check("sat_ecg_signal", bus2.ecg_signal, e.val);
        check("sat_beat_marker", bus2.beat_marker, e.mk);
        check("sat_no_wrap", int'(bus2.ecg_signal >= 16'd57535), 1);
      end
      if (sidx2 < 64) log2_v[sidx2] = bus2.ecg_signal;
      sidx2++;
    end
  end

  // Saturation instance: BASELINE + QRS_AMP lands exactly on 65535, so any noise saturates.
  initial begin : sat_stim
    exp_t e;
    rst2_n = 1'b0;
    bus2.enable = 1'b1;
    bus2.sample_tick = 1'b0;
    bus2.rr_period = 16'd100;
    bus2.noise_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst2_n = 1'b1;
    pos2 = 0;
    mbc2 = 0;
    mlfsr2 = 16'hACE1;
    for (int i = 0; i < 40; i++) begin
      e.val = emit(shape(pos2, 57535), mlfsr2, 1'b1);
      e.mk  = (pos2 == 15);
      if (e.mk) mbc2++;
      e.bc  = mbc2;
      q2.push_back(e);
      mlfsr2 = lfsr_next(mlfsr2);
      pos2++;
      bus2.sample_tick = 1'b1;
      @(posedge clk);
      #1;
    end
    bus2.sample_tick = 1'b0;
    for (int i = 0; i < 10 && q2.size() != 0; i++) @(posedge clk);
    #1;
    check("drain2_queue", q2.size(), 0);
    check("sat_r_peak", log2_v[15], 65535);
    done2 = 1'b1;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin : main
    int re_idx;
    int nmk;
    rst_n = 1'b0;
    bus1.enable = 1'b0;
    bus1.sample_tick = 1'b0;
    bus1.rr_period = 16'd100;
    bus1.noise_en = 1'b0;
    @(posedge clk);
    #1;
    reset1();

    // Nominal 100-sample beat, tick every cycle.
    bus1.enable = 1'b1;
    run1(120);
    drain1();
    check("s0_p_rise", log_v[0], 1100);
    check("s3_p_peak", log_v[3], 1400);
    check("s7_p_end", log_v[7], 1000);
    check("s15_r_peak", log_v[15], 9000);
    check("s15_marker", log_m[15], 1);
    check("s19_qrs_end", log_v[19], 1000);
    check("s115_marker", log_m[115], 1);
    check("s115_beat_count", log_bc[115], 2);

    // Drop enable on the tick of sample 12 of beat 3 (global sample 212).
    run1(92);
    bus1.sample_tick = 1'b1;
    bus1.enable = 1'b0;
    @(posedge clk);
    #1;
    pos = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("disabled_no_valid", bus1.sample_valid, 0);
      check("disabled_hold", bus1.ecg_signal, 1000);
      @(posedge clk);
      #1;
    end
    bus1.sample_tick = 1'b0;
    bus1.enable = 1'b1;
    re_idx = sidx;
    run1(5);
    drain1();
    check("reenable_first", log_v[re_idx], 1100);
    check("reenable_beat_count", log_bc[re_idx], 2);

    // Period below the fixed part clamps to 44.
    reset1();
    bus1.rr_period = 16'd10;
    run1(110);
    drain1();
    check("clamp_marker15", log_m[15], 1);
    check("clamp_marker59", log_m[59], 1);
    check("clamp_marker103", log_m[103], 1);
    check("clamp_no_base", log_v[44], 1100);
    nmk = 0;
    for (int i = 0; i < 110; i++) nmk += int'(log_m[i]);
    check("clamp_marker_total", nmk, 3);

    // Noise from reset.
    reset1();
    bus1.rr_period = 16'd100;
    bus1.noise_en = 1'b1;
    run1(20);
    drain1();
    check("noise_s0", log_v[0], 1101);
    check("noise_s1", log_v[1], 1203);
    bus1.noise_en = 1'b0;

    // Period change mid-beat takes effect at the next beat start, then reset mid-beat.
    reset1();
    bus1.rr_period = 16'd100;
    run1(50);
    bus1.rr_period = 16'd60;
    run1(130);
    drain1();
    check("rr_beat2_start", log_v[100], 1100);
    check("rr_beat2_marker", log_m[115], 1);
    check("rr_beat2_end", log_v[159], 1000);
    check("rr_beat3_start", log_v[160], 1100);
    check("rr_beat3_marker", log_m[175], 1);
    check("rr_beat3_count", log_bc[175], 3);
    run1(10);
    reset1();

    for (int i = 0; i < 200 && !done2; i++) @(posedge clk);
    check("sat_done", int'(done2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
